wave_phase_reader: RTL and testbench

- Consumer of the phase step and gain words produced by the button/switch control block.
- Accumulates phase at a fixed sample rate and addresses the waveform LUT ROM, which has registered output and 1-cycle read latency.
- Scales the returned sample by the 4-bit gain and emits one valid sample per sample tick.
- Sits between the control block and the DAC / filter chain.

---
 rtl/wave_pkg.sv | 16 +
 rtl/wave_phase_reader_if.sv | 29 ++
 rtl/wave_phase_reader_sample_tick_gen.sv | 30 +++
 rtl/wave_phase_reader.sv | 114 +++++++++++
 tb/tb_wave_phase_reader.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wave_pkg.sv
// Shared constants, the sample type and the address-width helper for the
// wave phase reader slice.
package wave_pkg;

  localparam int GAIN_W     = 4;
  localparam int GAIN_SHIFT = 4;
  localparam int DIV_MIN    = 4;
  localparam int SAMPLE_W   = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wave_phase_reader_if.sv
// LUT read bus plus scaled-sample output bundle of the wave phase reader.
interface wave_phase_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);

  logic        [ADDR_W-1:0] rom_addr;
  logic signed [DATA_W-1:0] rom_data;
  logic signed [DATA_W-1:0] sample;
  logic                     sample_valid;
  logic                     period_start;

  modport master (
    output rom_addr,
    input  rom_data,
    output sample,
    output sample_valid,
    output period_start
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  sample,
    input  sample_valid,
    input  period_start
  );

endinterface

// File: rtl/wave_phase_reader_sample_tick_gen.sv
// Sample-rate divider: one o_tick every DIV enabled clock cycles.
module sample_tick_gen
  import wave_pkg::*;
#(
  parameter int DIV = 50
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  // Shorter periods would let consecutive samples overlap in the read pipeline.
  localparam int DIV_EFF = (DIV < DIV_MIN) ? DIV_MIN : DIV;
  localparam int CNT_W   = $clog2(DIV_EFF);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    o_tick = i_en && (cnt_q == CNT_W'(DIV_EFF - 1));
    cnt_d  = cnt_q + 1'b1;
    if (!i_en || o_tick) cnt_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wave_phase_reader.sv
// Phase accumulator addressing a registered waveform LUT, with gain scaling
// and one valid strobe per sample tick; step/gain change only at period wrap.
module wave_phase_reader
  import wave_pkg::*;
#(
  parameter  int DEPTH  = 1024,
  parameter  int DATA_W = 16,
  parameter  int DIV    = 50,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic        [ADDR_W-1:0] i_phase_count_step,
  input  logic        [GAIN_W-1:0] i_wave_gain,
  output logic        [ADDR_W-1:0] o_rom_addr,
  input  logic signed [DATA_W-1:0] i_rom_data,
  output logic signed [DATA_W-1:0] o_sample,
  output logic                     o_sample_valid,
  output logic                     o_period_start
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;

  function automatic logic signed [DATA_W-1:0] scale_sample(
    input logic signed [DATA_W-1:0] d,
    input logic        [GAIN_W-1:0] g
  );
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(d) * PROD_W'($signed({1'b0, g}));
    prod = prod >>> GAIN_SHIFT;
    return prod[DATA_W-1:0];
  endfunction

  logic                     tick;
  logic                     load;
  logic        [ADDR_W:0]   sum;
  logic        [ADDR_W-1:0] phase_acc_q, phase_acc_d;
  logic        [ADDR_W-1:0] step_q, step_d;
  logic        [GAIN_W-1:0] gain_q, gain_d;
  logic                     wrap_q, wrap_d;
  logic        [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic                     pf_q, pf_d;
  logic                     vld_p0_q, vld_p0_d;
  logic                     vld_p1_q, vld_p1_d;
  logic signed [DATA_W-1:0] sample_q, sample_d;
  logic                     sample_vld_q, sample_vld_d;
  logic                     period_start_q, period_start_d;

  sample_tick_gen #(.DIV(DIV)) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .o_tick  (tick)
  );

  always_comb begin
    load           = tick && (wrap_q || (step_q == '0));
    step_d         = load ? i_phase_count_step : step_q;
    gain_d         = load ? i_wave_gain : gain_q;
    // DEPTH is a power of two, so the carry bit is the period wrap.
    sum            = {1'b0, phase_acc_q} + {1'b0, step_d};
    phase_acc_d    = phase_acc_q;
    wrap_d         = wrap_q;
    rom_addr_d     = rom_addr_q;
    pf_d           = pf_q;
    if (tick) begin
      rom_addr_d  = phase_acc_q;
      phase_acc_d = sum[ADDR_W-1:0];
      wrap_d      = sum[ADDR_W];
      pf_d        = wrap_q;
    end
    // Stage p0: address on the LUT; stage p1: LUT data valid and scaled.
    vld_p0_d       = tick;
    vld_p1_d       = vld_p0_q;
    sample_d       = vld_p1_q ? scale_sample(i_rom_data, gain_q) : sample_q;
    sample_vld_d   = vld_p1_q;
    period_start_d = vld_p1_q && pf_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_acc_q    <= '0;
      step_q         <= '0;
      gain_q         <= '0;
      wrap_q         <= 1'b1;
      rom_addr_q     <= '0;
      pf_q           <= 1'b0;
      vld_p0_q       <= 1'b0;
      vld_p1_q       <= 1'b0;
      sample_q       <= '0;
      sample_vld_q   <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      phase_acc_q    <= phase_acc_d;
      step_q         <= step_d;
      gain_q         <= gain_d;
      wrap_q         <= wrap_d;
      rom_addr_q     <= rom_addr_d;
      pf_q           <= pf_d;
      vld_p0_q       <= vld_p0_d;
      vld_p1_q       <= vld_p1_d;
      sample_q       <= sample_d;
      sample_vld_q   <= sample_vld_d;
      period_start_q <= period_start_d;
    end
  end

  assign o_rom_addr     = rom_addr_q;
  assign o_sample       = sample_q;
  assign o_sample_valid = sample_vld_q;
  assign o_period_start = period_start_q;

endmodule

// File: tb/tb_wave_phase_reader.sv
// Self-checking bench for wave_phase_reader: directed scenarios plus random
// step/gain/enable traffic against an arithmetic reference model.
module tb_wave_phase_reader;
  import wave_pkg::*;

  localparam int DEPTH  = 1024;
  localparam int DATA_W = 16;
  localparam int DIV    = 50;
  localparam int ADDR_W = 10;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              en    = 1'b0;
  logic [ADDR_W-1:0] step  = '0;
  logic [3:0]        gain  = '0;

  wave_phase_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wave_phase_reader #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DIV(DIV)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_en               (en),
    .i_phase_count_step (step),
    .i_wave_gain        (gain),
    .o_rom_addr         (bus.rom_addr),
    .i_rom_data         (bus.rom_data),
    .o_sample           (bus.sample),
    .o_sample_valid     (bus.sample_valid),
    .o_period_start     (bus.period_start)
  );

  always #5 clk = ~clk;

  sample_t rom [DEPTH];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  typedef struct {
    int due;
    int smp;
    int pf;
  } exp_t;

  exp_t q[$];
  int   st_cyc[$], st_smp[$], st_pf[$], st_addr[$];
  int   mcnt, macc, mstep, mgain, mwrap, exp_addr, last_smp, cyc_n;
  bit   ticked;
  int   checks   = 0;
  int   failures = 0;
  int   tcyc;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mcnt = 0; macc = 0; mstep = 0; mgain = 0; mwrap = 1;
    exp_addr = 0; last_smp = 0; cyc_n = 0;
    q.delete();
  endtask

  task automatic clr_st();
    st_cyc.delete(); st_smp.delete(); st_pf.delete(); st_addr.delete();
  endtask

  // Predict the upcoming edge from current inputs, then check the cycle after it.
  task automatic cyc();
    int   tk, a, s;
    exp_t e;
    ticked = 0;
    tk   = (en && mcnt == DIV - 1) ? 1 : 0;
    mcnt = (!en || tk != 0) ? 0 : mcnt + 1;
    if (tk != 0) begin
      if (mwrap != 0 || mstep == 0) begin
        mstep = int'(step);
        mgain = int'(gain);
      end
      a     = macc;
      s     = macc + mstep;
      e.due = cyc_n + 3;
      e.smp = (int'(rom[a]) * mgain) >>> 4;
      e.pf  = mwrap;
      q.push_back(e);
      mwrap    = (s >= DEPTH) ? 1 : 0;
      macc     = s % DEPTH;
      exp_addr = a;
      ticked   = 1;
    end
    @(negedge clk);
    cyc_n++;
    chk("rom_addr", int'(bus.rom_addr), exp_addr);
    if (q.size() > 0 && q[0].due == cyc_n) begin
      chk("valid", int'(bus.sample_valid), 1);
      chk("sample", int'(bus.sample), q[0].smp);
      chk("period_start", int'(bus.period_start), q[0].pf);
      last_smp = q[0].smp;
      st_cyc.push_back(cyc_n);
      st_smp.push_back(int'(bus.sample));
      st_pf.push_back(int'(bus.period_start));
      st_addr.push_back(int'(bus.rom_addr));
      void'(q.pop_front());
    end else begin
      chk("valid_idle", int'(bus.sample_valid), 0);
      chk("period_start_idle", int'(bus.period_start), 0);
      chk("sample_hold", int'(bus.sample), last_smp);
    end
  endtask

  task automatic run_to_tick(input int budget);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!ticked && n < budget);
    chk("tick_within_budget", int'(ticked), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rom_addr", int'(bus.rom_addr), 0);
    chk("rst_sample", int'(bus.sample), 0);
    chk("rst_valid", int'(bus.sample_valid), 0);
    chk("rst_period_start", int'(bus.period_start), 0);
    model_reset();
    clr_st();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = sample_t'(i * 8);
    #2;
    do_reset();

    // Basic: step 1, gain 15, ROM = addr*8
    en = 1'b1; step = 10'd1; gain = 4'd15;
    repeat (110) cyc();
    chk("p1_strobes", st_cyc.size(), 2);
    chk("p1_first_cyc", st_cyc[0], 52);
    chk("p1_first_addr", st_addr[0], 0);
    chk("p1_first_smp", st_smp[0], 0);
    chk("p1_first_pf", st_pf[0], 1);
    chk("p1_second_cyc", st_cyc[1], 102);
    chk("p1_second_addr", st_addr[1], 1);
    chk("p1_second_smp", st_smp[1], 7);
    chk("p1_second_pf", st_pf[1], 0);

    // Step 64 sweeps the table in 16 samples
    do_reset();
    en = 1'b1; step = 10'd64; gain = 4'd15;
    repeat (860) cyc();
    chk("p2_strobes", st_cyc.size(), 17);
    for (int k = 0; k < 17; k++) begin
      chk("p2_addr", st_addr[k], (k * 64) % DEPTH);
      chk("p2_pf", st_pf[k], (k % 16 == 0) ? 1 : 0);
    end

    // Step/gain change mid-period only takes effect after the wrap
    do_reset();
    rom[0] = sample_t'(-32768);
    en = 1'b1; step = 10'd1023; gain = 4'd15;
    run_to_tick(60);
    step = 10'd1;
    run_to_tick(60);
    run_to_tick(60);
    step = 10'd16; gain = 4'd8;
    run_to_tick(60);
    run_to_tick(60);
    run_to_tick(60);
    repeat (3) cyc();
    chk("p3_strobes", st_cyc.size(), 6);
    chk("p3_pre_wrap_addr", st_addr[3], 1023);
    chk("p3_pre_wrap_smp", st_smp[3], 7672);
    chk("p3_post_wrap_addr", st_addr[4], 0);
    chk("p3_post_wrap_smp", st_smp[4], -16384);
    chk("p3_post_wrap_pf", st_pf[4], 1);
    chk("p3_step16_addr", st_addr[5], 16);
    chk("p3_step16_smp", st_smp[5], 64);

    // Negative data floors, small positive data vanishes, gain 0 still strobes
    do_reset();
    rom[0] = sample_t'(-1);
    en = 1'b1; step = 10'd0; gain = 4'd1;
    repeat (160) cyc();
    for (int k = 0; k < 3; k++) begin
      chk("p4_neg_smp", st_smp[k], -1);
      chk("p4_step0_addr", st_addr[k], 0);
      chk("p4_step0_pf", st_pf[k], (k == 0) ? 1 : 0);
    end
    rom[0] = sample_t'(15);
    repeat (50) cyc();
    chk("p4_pos15_smp", st_smp[3], 0);
    rom[0] = sample_t'(-32768); gain = 4'd0;
    repeat (50) cyc();
    chk("p4_gain0_strobes", st_cyc.size(), 5);
    chk("p4_gain0_smp", st_smp[4], 0);

    // Enable drop one cycle after a tick
    do_reset();
    for (int i = 0; i < DEPTH; i++) rom[i] = sample_t'($urandom);
    en = 1'b1; step = 10'd37; gain = 4'd9;
    run_to_tick(60);
    run_to_tick(60);
    en = 1'b0;
    tcyc = cyc_n;
    repeat (200) cyc();
    chk("p5_strobes_disabled", st_cyc.size(), 2);
    chk("p5_pending_cyc", st_cyc[1], tcyc + 2);
    en = 1'b1;
    repeat (110) cyc();
    chk("p5_strobes_resumed", st_cyc.size(), 4);
    chk("p5_resume_addr", st_addr[2], 74);

    // Random step/gain/enable traffic
    do_reset();
    en = 1'b1;
    step = 10'($urandom_range(1, 1023));
    gain = 4'($urandom_range(0, 15));
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 99) == 0)
        step = ($urandom_range(0, 15) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      if ($urandom_range(0, 99) == 0) gain = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) en = ~en;
      cyc();
    end

    // Reset one cycle after a tick kills the in-flight sample
    en = 1'b1; step = 10'd300; gain = 4'd12;
    run_to_tick(120);
    run_to_tick(120);
    do_reset();
    en = 1'b1;
    repeat (60) cyc();
    chk("p7_strobes", st_cyc.size(), 1);
    chk("p7_restart_cyc", st_cyc[0], 52);
    chk("p7_restart_addr", st_addr[0], 0);
    chk("p7_restart_pf", st_pf[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
